// File: rtl/word_loader.sv
// word_loader: splits a valid/ready byte stream into words on 0x00/0x20
// delimiters, writes each word null-terminated into the matcher's input-word
// SRAM, restarts and launches the matcher, waits for done with a timeout and
// reports hit/timeout/truncation per word.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   byte stream handshake (in_ready decodes from state)
//   wr_en/wr_addr/wr_data   input-word SRAM write port (registered)
//   match_rst_n             matcher reset, low in TERM or while rst_n is low
//   match_cs                one-cycle matcher start pulse (registered)
//   match_done/match_hit    matcher status inputs
//   result_valid            one-cycle pulse per completed word
//   result_hit/timeout/trunc    per-word status, held until the next report
//   word_count              completed words, saturating
module word_loader #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  match_rst_n,
    output logic                  match_cs,
    input  logic                  match_done,
    input  logic                  match_hit,
    output logic                  result_valid,
    output logic                  result_hit,
    output logic                  result_timeout,
    output logic                  result_trunc,
    output logic [15:0]           word_count
);
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LEN_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] CHAR_NUL  = '0;
    localparam logic [DATA_WIDTH-1:0] CHAR_SPC  = DATA_WIDTH'(32);

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_TERM,
        ST_START,
        ST_WAIT,
        ST_REPORT
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] len, len_nxt;
    logic                  trunc, trunc_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic                  wr_en_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [DATA_WIDTH-1:0] wr_data_nxt;
    logic                  match_cs_nxt;
    logic                  result_valid_nxt;
    logic                  result_hit_nxt;
    logic                  result_timeout_nxt;
    logic                  result_trunc_nxt;
    logic [15:0]           word_count_nxt;
    logic                  is_delim;

    assign is_delim    = (in_data == CHAR_NUL) || (in_data == CHAR_SPC);
    assign in_ready    = (state == ST_COLLECT);
    assign match_rst_n = rst_n && (state != ST_TERM);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_COLLECT;
            len            <= '0;
            trunc          <= 1'b0;
            cnt            <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            match_cs       <= 1'b0;
            result_valid   <= 1'b0;
            result_hit     <= 1'b0;
            result_timeout <= 1'b0;
            result_trunc   <= 1'b0;
            word_count     <= '0;
        end else begin
            state          <= state_nxt;
            len            <= len_nxt;
            trunc          <= trunc_nxt;
            cnt            <= cnt_nxt;
            wr_en          <= wr_en_nxt;
            wr_addr        <= wr_addr_nxt;
            wr_data        <= wr_data_nxt;
            match_cs       <= match_cs_nxt;
            result_valid   <= result_valid_nxt;
            result_hit     <= result_hit_nxt;
            result_timeout <= result_timeout_nxt;
            result_trunc   <= result_trunc_nxt;
            word_count     <= word_count_nxt;
        end
    end

    // Next-state and next-output decode; outputs land one cycle after the decision
    always_comb begin
        state_nxt          = state;
        len_nxt            = len;
        trunc_nxt          = trunc;
        cnt_nxt            = cnt;
        wr_en_nxt          = 1'b0;
        wr_addr_nxt        = wr_addr;
        wr_data_nxt        = wr_data;
        match_cs_nxt       = 1'b0;
        result_valid_nxt   = 1'b0;
        result_hit_nxt     = result_hit;
        result_timeout_nxt = result_timeout;
        result_trunc_nxt   = result_trunc;
        word_count_nxt     = word_count;

        unique case (state)
            ST_COLLECT: begin
                if (in_valid) begin
                    if (is_delim) begin
                        // Terminator write is issued so it is on the port during TERM
                        if (len != '0) begin
                            state_nxt   = ST_TERM;
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = len;
                            wr_data_nxt = CHAR_NUL;
                        end
                    end else if (len != LEN_MAX) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = len;
                        wr_data_nxt = in_data;
                        len_nxt     = len + ADDR_WIDTH'(1);
                    end else begin
                        trunc_nxt = 1'b1;
                    end
                end
            end
            ST_TERM: begin
                match_cs_nxt = 1'b1;
                state_nxt    = ST_START;
            end
            ST_START: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over a timeout landing in the same cycle
                if (match_done || (cnt == CNT_LAST)) begin
                    state_nxt          = ST_REPORT;
                    result_valid_nxt   = 1'b1;
                    result_hit_nxt     = match_done && match_hit;
                    result_timeout_nxt = !match_done;
                    result_trunc_nxt   = trunc;
                    if (word_count != 16'hFFFF) begin
                        word_count_nxt = word_count + 16'd1;
                    end
                    len_nxt   = '0;
                    trunc_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            ST_REPORT: begin
                state_nxt = ST_COLLECT;
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase
    end

endmodule
